// File: rtl/rsa_pkg.sv
// Shared RSA definitions: default widths, controller state encoding and the constant one.
package rsa_pkg;

    localparam int unsigned RSA_W   = 2048;
    localparam int unsigned RSA_E_W = 32;

    localparam logic [RSA_W-1:0] RSA_ONE = {{(RSA_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StSqr,
        StMul,
        StDone
    } rsa_state_e;

endpackage

// File: rtl/mod_mul.sv
// Bit-serial Blakley modular multiplier: p = a*b mod n in one launch cycle plus W iterations.
module mod_mul #(
    parameter int unsigned W = 2048
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] n,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] p
);

    localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]    a_q, b_q, n_q, p_q;
    logic [CntW-1:0] cnt_q;
    logic            busy_q;
    logic [W+1:0]    acc;

    // 2P + b < 3n, so two conditional subtractions bring the accumulator back below n.
    always_comb begin
        acc = {1'b0, p_q, 1'b0};
        if (a_q[W-1]) begin
            acc = acc + {2'b00, b_q};
        end
        if (acc >= {2'b00, n_q}) begin
            acc = acc - {2'b00, n_q};
        end
        if (acc >= {2'b00, n_q}) begin
            acc = acc - {2'b00, n_q};
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == '0);
    assign p    = acc[W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            n_q    <= '0;
            p_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start && !busy_q) begin
            a_q    <= a;
            b_q    <= b;
            n_q    <= n;
            p_q    <= '0;
            cnt_q  <= CntW'(W - 1);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            p_q   <= acc[W-1:0];
            a_q   <= a_q << 1;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/encrypt.sv
// RSA encryption C = m^e mod n: left-to-right square-and-multiply over every exponent bit.
module encrypt
    import rsa_pkg::*;
#(
    parameter int unsigned W   = RSA_W,
    parameter int unsigned E_W = RSA_E_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [E_W-1:0] e,
    input  logic [W-1:0]   n,
    input  logic [W-1:0]   m,
    input  logic           ready,
    output logic [W-1:0]   C,
    output logic           valid,
    output logic           err
);

    localparam int unsigned IdxW = (E_W > 1) ? $clog2(E_W) : 1;

    rsa_state_e     state_q;
    logic [E_W-1:0] ein_q;
    logic [W-1:0]   nin_q, min_q, r_q, c_q;
    logic [IdxW-1:0] idx_q;
    logic           err_q;

    logic           mm_start, mm_busy, mm_done;
    logic [W-1:0]   mm_b, mm_p;

    assign mm_start = ((state_q == StSqr) || (state_q == StMul)) && !mm_busy;
    assign mm_b     = (state_q == StMul) ? min_q : r_q;

    mod_mul #(
        .W(W)
    ) u_mod_mul (
        .clk  (clk),
        .reset(reset),
        .start(mm_start),
        .a    (r_q),
        .b    (mm_b),
        .n    (nin_q),
        .busy (mm_busy),
        .done (mm_done),
        .p    (mm_p)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ein_q   <= '0;
            nin_q   <= '0;
            min_q   <= '0;
            r_q     <= '0;
            c_q     <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (ready) begin
                        ein_q   <= e;
                        nin_q   <= n;
                        min_q   <= m;
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    if ((nin_q == '0) || (min_q >= nin_q)) begin
                        err_q   <= 1'b1;
                        r_q     <= '0;
                        c_q     <= '0;
                        state_q <= StDone;
                    end else begin
                        // Anything mod 1 is 0, so the running product starts there.
                        r_q     <= (nin_q == W'(1)) ? '0 : W'(RSA_ONE);
                        idx_q   <= IdxW'(E_W - 1);
                        state_q <= StSqr;
                    end
                end
                StSqr: begin
                    if (mm_done) begin
                        r_q <= mm_p;
                        if (ein_q[idx_q]) begin
                            state_q <= StMul;
                        end else if (idx_q == '0) begin
                            c_q     <= mm_p;
                            state_q <= StDone;
                        end else begin
                            idx_q <= idx_q - 1'b1;
                        end
                    end
                end
                StMul: begin
                    if (mm_done) begin
                        r_q <= mm_p;
                        if (idx_q == '0) begin
                            c_q     <= mm_p;
                            state_q <= StDone;
                        end else begin
                            idx_q   <= idx_q - 1'b1;
                            state_q <= StSqr;
                        end
                    end
                end
                StDone: begin
                    if (!ready) begin
                        err_q   <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign valid = (state_q == StDone) && ready;
    assign C     = c_q;
    assign err   = err_q;

endmodule

// File: tb/tb_encrypt.sv
// Self-checking bench for encrypt at W=16, E_W=5: vector table, handshake corners, random sweep.
module tb_encrypt;
    import rsa_pkg::*;

    localparam int unsigned W       = 16;
    localparam int unsigned E_W     = 5;
    localparam int          MUL_CYC = W + 1;
    localparam int          TIMEOUT = 400;

    typedef struct {
        logic [E_W-1:0] e;
        logic [W-1:0]   n;
        logic [W-1:0]   m;
        logic [W-1:0]   c;
        logic           err;
    } vec_t;

    typedef struct {
        logic [W-1:0] c;
        logic         err;
        int           lat;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           ready;
    logic [E_W-1:0] e;
    logic [W-1:0]   n, m, C;
    logic           valid, err;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    vec_t vecs[10];

    always #5 clk = ~clk;

    encrypt #(
        .W  (W),
        .E_W(E_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .e    (e),
        .n    (n),
        .m    (m),
        .ready(ready),
        .C    (C),
        .valid(valid),
        .err  (err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int nominal_lat(input logic [E_W-1:0] ev);
        return 2 + (E_W + $countones(ev)) * MUL_CYC;
    endfunction

    function automatic exp_t model(input logic [E_W-1:0] ev, input logic [W-1:0] nv,
                                   input logic [W-1:0] mv);
        exp_t x;
        longint unsigned r;
        if (nv == 0 || mv >= nv) begin
            x.c = '0; x.err = 1'b1; x.lat = 2;
        end else begin
            r = (nv == 1) ? 0 : 1;
            for (int i = E_W - 1; i >= 0; i--) begin
                r = (r * r) % nv;
                if (ev[i]) r = (r * mv) % nv;
            end
            x.c = W'(r); x.err = 1'b0; x.lat = nominal_lat(ev);
        end
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives operands with ready high and returns just after the capture edge.
    task automatic start_op(input logic [E_W-1:0] ev, input logic [W-1:0] nv,
                            input logic [W-1:0] mv);
        e = ev; n = nv; m = mv; ready = 1'b1;
        tick();
    endtask

    // cnt is the number of edges already seen since (and including) the capture edge.
    task automatic finish_op(input string tag, input int cnt_in);
        exp_t x;
        int cnt;
        cnt = cnt_in;
        while (!valid && cnt < TIMEOUT) begin
            tick();
            cnt++;
        end
        x = sb.pop_front();
        if (!valid) begin
            check({tag, "_timeout"}, 64'(valid), 64'(1));
        end else begin
            check({tag, "_lat"}, 64'(cnt), 64'(x.lat));
            check({tag, "_C"}, 64'(C), 64'(x.c));
            check({tag, "_err"}, 64'(err), 64'(x.err));
        end
        ready = 1'b0;
        #1;
        check({tag, "_valid_drop"}, 64'(valid), 64'(0));
        tick();
    endtask

    initial begin
        int   seen;
        exp_t x;

        vecs[0] = '{e: 5'd17, n: 16'd3233, m: 16'd65,   c: 16'd2790, err: 1'b0};
        vecs[1] = '{e: 5'd17, n: 16'd3233, m: 16'd0,    c: 16'd0,    err: 1'b0};
        vecs[2] = '{e: 5'd0,  n: 16'd3233, m: 16'd65,   c: 16'd1,    err: 1'b0};
        vecs[3] = '{e: 5'd17, n: 16'd3233, m: 16'd3233, c: 16'd0,    err: 1'b1};
        vecs[4] = '{e: 5'd17, n: 16'd3233, m: 16'd65,   c: 16'd2790, err: 1'b0};
        vecs[5] = '{e: 5'd17, n: 16'd0,    m: 16'd5,    c: 16'd0,    err: 1'b1};
        vecs[6] = '{e: 5'd2,  n: 16'd3233, m: 16'd65,   c: 16'd992,  err: 1'b0};
        vecs[7] = '{e: 5'd3,  n: 16'd3233, m: 16'd65,   c: 16'd3053, err: 1'b0};
        vecs[8] = '{e: 5'd17, n: 16'd3233, m: 16'd3232, c: 16'd3232, err: 1'b0};
        vecs[9] = '{e: 5'd17, n: 16'd1,    m: 16'd0,    c: 16'd0,    err: 1'b0};

        reset = 1'b1; ready = 1'b0; e = '0; n = '0; m = '0;
        repeat (3) tick();
        check("reset_C", 64'(C), 64'(0));
        check("reset_valid", 64'(valid), 64'(0));
        check("reset_err", 64'(err), 64'(0));
        reset = 1'b0;
        tick();

        foreach (vecs[i]) begin
            x.c   = vecs[i].c;
            x.err = vecs[i].err;
            x.lat = vecs[i].err ? 2 : nominal_lat(vecs[i].e);
            sb.push_back(x);
            start_op(vecs[i].e, vecs[i].n, vecs[i].m);
            finish_op($sformatf("vec%0d", i), 1);
        end

        // Inputs scrambled and ready dropped mid-SQR; captured operands must win.
        sb.push_back(model(5'd17, 16'd3233, 16'd65));
        start_op(5'd17, 16'd3233, 16'd65);
        repeat (3) tick();
        ready = 1'b0; e = 5'd3; n = 16'd999; m = 16'd7;
        repeat (20) tick();
        ready = 1'b1;
        finish_op("scramble", 24);

        // Ready low when the result lands: valid must never show, then a re-request completes.
        start_op(5'd17, 16'd3233, 16'd65);
        repeat (3) tick();
        ready = 1'b0;
        seen = 0;
        repeat (150) begin
            tick();
            if (valid) seen = 1;
        end
        check("done_ready_low_valid", 64'(seen), 64'(0));
        sb.push_back(model(5'd17, 16'd3233, 16'd65));
        start_op(5'd17, 16'd3233, 16'd65);
        finish_op("rerequest", 1);

        // Reset while in the first MUL (edges 19..35 after capture).
        start_op(5'd17, 16'd3233, 16'd65);
        repeat (29) tick();
        ready = 1'b0;
        reset = 1'b1;
        tick();
        check("rst_mid_C", 64'(C), 64'(0));
        check("rst_mid_valid", 64'(valid), 64'(0));
        check("rst_mid_err", 64'(err), 64'(0));
        check("rst_mid_state", 64'(dut.state_q), 64'(StIdle));
        reset = 1'b0;
        tick();
        sb.push_back(model(5'd17, 16'd3233, 16'd65));
        start_op(5'd17, 16'd3233, 16'd65);
        finish_op("after_rst", 1);

        for (int k = 0; k < 100; k++) begin
            logic [W-1:0]   rn, rm;
            logic [E_W-1:0] re;
            rn = W'($urandom_range(1, 65535)) | W'(1);
            rm = W'($urandom_range(0, 32'(rn) - 1));
            re = E_W'($urandom_range(0, 31));
            sb.push_back(model(re, rn, rm));
            start_op(re, rn, rm);
            finish_op($sformatf("rnd%0d", k), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
